// File: rtl/proc_sched.sv
// -----------------------------------------------------------------------------
// proc_sched
//   Control sequencer for one processing slot. A packet taken from the input
//   queue is walked through a chain of NUM_STAGES engines using a one-cycle
//   start pulse and a level ready. Each engine may be bypassed per packet, may
//   request a drop, and is guarded by a watchdog. After the chain, the packet is
//   committed: the input queue is popped, and the output queue is written only
//   if the packet is forwarded. Saturating counters track forwarded packets,
//   dropped packets and watchdog expiries.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   in_empty_i     input queue empty
//   in_rd_o        input queue pop, one-cycle pulse
//   out_empty_i    output slot free (1 = may write)
//   out_wr_o       output queue write, one-cycle pulse
//   stage_start_o  one-hot start pulse to engine i
//   stage_ready_i  engine i done (level)
//   stage_drop_i   engine i requests drop, qualified by stage_ready_i[i]
//   cfg_bypass_i   per-stage skip mask, sampled at packet accept
//   cfg_timeout_i  watchdog limit in WAIT cycles, 0 disables; sampled at accept
//   clr_cnt_i      synchronous clear of all statistics counters
//   busy_o         a packet is in flight
//   cur_stage_o    active stage index, 0 when idle
//   pkt_cnt_o      packets forwarded
//   drop_cnt_o     packets dropped, including watchdog drops
//   timeout_cnt_o  watchdog expiries
// -----------------------------------------------------------------------------
module proc_sched #(
    parameter int NUM_STAGES = 3,
    parameter int TIMEOUT_W  = 16,
    parameter int CNT_W      = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_empty_i,
    output logic                              in_rd_o,
    input  logic                              out_empty_i,
    output logic                              out_wr_o,
    output logic [NUM_STAGES-1:0]             stage_start_o,
    input  logic [NUM_STAGES-1:0]             stage_ready_i,
    input  logic [NUM_STAGES-1:0]             stage_drop_i,
    input  logic [NUM_STAGES-1:0]             cfg_bypass_i,
    input  logic [TIMEOUT_W-1:0]              cfg_timeout_i,
    input  logic                              clr_cnt_i,
    output logic                              busy_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]   cur_stage_o,
    output logic [CNT_W-1:0]                  pkt_cnt_o,
    output logic [CNT_W-1:0]                  drop_cnt_o,
    output logic [CNT_W-1:0]                  timeout_cnt_o
);

    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [2:0] {
        S_FREE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_OUT_WAIT = 3'd3,
        S_DROP     = 3'd4,
        S_LATCH    = 3'd5
    } state_t;

    // Counter slots in r_cnt
    localparam int C_PKT  = 0;
    localparam int C_DROP = 1;
    localparam int C_TO   = 2;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    r_fwd;
    logic                    w_fwd_next;
    logic [TIMEOUT_W-1:0]    r_timer;
    logic [TIMEOUT_W-1:0]    r_limit;
    logic [NUM_STAGES-1:0]   r_bypass;
    logic                    w_accept;
    logic                    w_timeout;

    logic                    w_first_found;
    logic [IDX_W-1:0]        w_first_idx;
    logic                    w_above_found;
    logic [IDX_W-1:0]        w_above_idx;

    logic [NUM_STAGES-1:0]   w_sel_cur;
    logic [NUM_STAGES-1:0]   w_sel_next;
    logic                    w_rdy;
    logic                    w_drop;

    logic                    r_in_rd;
    logic                    r_out_wr;
    logic [NUM_STAGES-1:0]   r_start;
    logic                    r_busy;
    logic [IDX_W-1:0]        r_cur_stage;

    logic [CNT_W-1:0]        r_cnt [3];
    logic [2:0]              w_cnt_inc;

    // One-hot decode of the current and the upcoming stage index
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
            assign w_sel_cur[gi]  = (r_idx == IDX_W'(gi));
            assign w_sel_next[gi] = (w_idx_next == IDX_W'(gi));
        end
    endgenerate

    assign w_rdy  = |(stage_ready_i & w_sel_cur);
    assign w_drop = |(stage_ready_i & stage_drop_i & w_sel_cur);

    // Lowest unbypassed stage overall (from the live config, used at accept)
    // and lowest unbypassed stage above the current one (from the latched mask).
    // Scanning downward lets the lowest match overwrite higher ones.
    always_comb begin
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_above_found = 1'b0;
        w_above_idx   = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!cfg_bypass_i[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = IDX_W'(i);
            end
            if (!r_bypass[i] && (i > int'(r_idx))) begin
                w_above_found = 1'b1;
                w_above_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_fwd_next   = r_fwd;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_FREE: begin
                if (!in_empty_i) begin
                    w_accept = 1'b1;
                    if (w_first_found) begin
                        w_state_next = S_START;
                        w_idx_next   = w_first_idx;
                    end else begin
                        w_state_next = S_OUT_WAIT;
                        w_idx_next   = '0;
                    end
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // Ready takes priority over a watchdog expiry in the same cycle
                if (w_rdy) begin
                    if (w_drop) begin
                        w_state_next = S_DROP;
                    end else if (w_above_found) begin
                        w_state_next = S_START;
                        w_idx_next   = w_above_idx;
                    end else begin
                        w_state_next = S_OUT_WAIT;
                    end
                end else if ((r_limit != '0) && (r_timer == r_limit - TIMEOUT_W'(1))) begin
                    w_state_next = S_DROP;
                    w_timeout    = 1'b1;
                end
            end
            S_OUT_WAIT: begin
                if (out_empty_i) begin
                    w_state_next = S_LATCH;
                    w_fwd_next   = 1'b1;
                end
            end
            S_DROP: begin
                w_state_next = S_LATCH;
                w_fwd_next   = 1'b0;
            end
            S_LATCH: begin
                w_state_next = S_FREE;
                w_idx_next   = '0;
            end
            default: begin
                w_state_next = S_FREE;
                w_idx_next   = '0;
            end
        endcase
    end

    // State, index, timer and latched configuration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FREE;
            r_idx    <= '0;
            r_fwd    <= 1'b0;
            r_timer  <= '0;
            r_limit  <= '0;
            r_bypass <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_fwd   <= w_fwd_next;
            if (w_accept) begin
                r_bypass <= cfg_bypass_i;
                r_limit  <= cfg_timeout_i;
            end
            if (r_state == S_START) begin
                r_timer <= '0;
            end else if ((r_state == S_WAIT) && !w_rdy) begin
                r_timer <= r_timer + TIMEOUT_W'(1);
            end
        end
    end

    // Outputs are registered from the next state so that each pulse lines up
    // exactly with the cycle spent in the corresponding state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_rd     <= 1'b0;
            r_out_wr    <= 1'b0;
            r_start     <= '0;
            r_busy      <= 1'b0;
            r_cur_stage <= '0;
        end else begin
            r_in_rd     <= (w_state_next == S_LATCH);
            r_out_wr    <= (w_state_next == S_LATCH) && w_fwd_next;
            r_start     <= (w_state_next == S_START) ? w_sel_next : '0;
            r_busy      <= (w_state_next != S_FREE);
            r_cur_stage <= (w_state_next == S_FREE) ? '0 : w_idx_next;
        end
    end

    // Statistics counters; clear beats increment, increments stop at all-ones
    assign w_cnt_inc[C_PKT]  = (r_state == S_LATCH) && r_fwd;
    assign w_cnt_inc[C_DROP] = (r_state == S_LATCH) && !r_fwd;
    assign w_cnt_inc[C_TO]   = w_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr_cnt_i) begin
                    r_cnt[i] <= '0;
                end else if (w_cnt_inc[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign in_rd_o       = r_in_rd;
    assign out_wr_o      = r_out_wr;
    assign stage_start_o = r_start;
    assign busy_o        = r_busy;
    assign cur_stage_o   = r_cur_stage;
    assign pkt_cnt_o     = r_cnt[C_PKT];
    assign drop_cnt_o    = r_cnt[C_DROP];
    assign timeout_cnt_o = r_cnt[C_TO];

endmodule

// File: tb/tb_proc_sched.sv
// -----------------------------------------------------------------------------
// tb_proc_sched
//   Directed bench for proc_sched with three stages and 4-bit counters.
//   Each table record describes one packet: config, engine latencies (-1 means
//   the engine never answers), drop requests, when the output slot frees up,
//   and the hand-computed expected starts, accept-to-LATCH latency, outcome and
//   whether a watchdog expiry occurs. Engines are modelled inside run_pkt.
// -----------------------------------------------------------------------------
module tb_proc_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_empty_i = 1'b1;
    logic        out_empty_i = 1'b1;
    logic [2:0]  stage_ready_i = '0;
    logic [2:0]  stage_drop_i = '0;
    logic [2:0]  cfg_bypass_i = '0;
    logic [15:0] cfg_timeout_i = '0;
    logic        clr_cnt_i = 1'b0;
    logic        in_rd_o;
    logic        out_wr_o;
    logic [2:0]  stage_start_o;
    logic        busy_o;
    logic [1:0]  cur_stage_o;
    logic [3:0]  pkt_cnt_o;
    logic [3:0]  drop_cnt_o;
    logic [3:0]  timeout_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int m_pkt = 0;
    int m_drop = 0;
    int m_to = 0;

    proc_sched #(.NUM_STAGES(3), .TIMEOUT_W(16), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_empty_i    (in_empty_i),
        .in_rd_o       (in_rd_o),
        .out_empty_i   (out_empty_i),
        .out_wr_o      (out_wr_o),
        .stage_start_o (stage_start_o),
        .stage_ready_i (stage_ready_i),
        .stage_drop_i  (stage_drop_i),
        .cfg_bypass_i  (cfg_bypass_i),
        .cfg_timeout_i (cfg_timeout_i),
        .clr_cnt_i     (clr_cnt_i),
        .busy_o        (busy_o),
        .cur_stage_o   (cur_stage_o),
        .pkt_cnt_o     (pkt_cnt_o),
        .drop_cnt_o    (drop_cnt_o),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  bypass;
        logic [15:0] tmo;
        int          d0;
        int          d1;
        int          d2;
        logic [2:0]  drop;
        int          out_free_at;
        logic [2:0]  exp_starts;
        int          exp_lat;
        bit          exp_fwd;
        bit          exp_to;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x >= 15) ? 15 : x + 1;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, " pkt_cnt"}, int'(pkt_cnt_o), m_pkt);
        check({tag, " drop_cnt"}, int'(drop_cnt_o), m_drop);
        check({tag, " timeout_cnt"}, int'(timeout_cnt_o), m_to);
    endtask

    // Runs one packet. Entered and left at 1 time unit after a rising edge
    // with the DUT in FREE; cycle 0 is the accept cycle.
    task automatic run_pkt(input string tag, input vec_t v, input bit clr_at_latch);
        int   start_c [3];
        bit   started [3];
        int   dly [3];
        int   latch_c;
        int   n_rd;
        int   n_wr;
        int   last;
        bit   done;
        logic [2:0] seen;
        dly[0] = v.d0;
        dly[1] = v.d1;
        dly[2] = v.d2;
        for (int i = 0; i < 3; i++) begin
            start_c[i] = 0;
            started[i] = 1'b0;
        end
        latch_c = 0;
        n_rd = 0;
        n_wr = 0;
        last = -1;
        done = 1'b0;
        seen = '0;
        cfg_bypass_i  = v.bypass;
        cfg_timeout_i = v.tmo;
        in_empty_i    = 1'b0;
        out_empty_i   = (v.out_free_at == 0);
        stage_ready_i = '0;
        stage_drop_i  = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                // Scramble config after accept: the DUT must use latched values
                in_empty_i    = 1'b1;
                cfg_bypass_i  = ~v.bypass;
                cfg_timeout_i = '0;
                check({tag, " busy after accept"}, int'(busy_o), 1);
            end
            if (in_rd_o) n_rd++;
            if (out_wr_o) n_wr++;
            if (latch_c > 0) begin
                clr_cnt_i = 1'b0;
                done = 1'b1;
                break;
            end
            check({tag, " start one-hot"}, int'($countones(stage_start_o) <= 1), 1);
            for (int i = 0; i < 3; i++) begin
                if (stage_start_o[i]) begin
                    check({tag, " repeated start"}, int'(started[i]), 0);
                    check({tag, " start order"}, int'(i > last), 1);
                    check({tag, " cur_stage at start"}, int'(cur_stage_o), i);
                    started[i] = 1'b1;
                    start_c[i] = c;
                    last = i;
                    seen[i] = 1'b1;
                end
            end
            if (in_rd_o) begin
                latch_c = c;
                if (clr_at_latch) clr_cnt_i = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                stage_ready_i[i] = started[i] && (dly[i] >= 0) && ((c - start_c[i]) >= dly[i]);
                stage_drop_i[i]  = stage_ready_i[i] && v.drop[i];
            end
            out_empty_i = (c >= v.out_free_at);
        end
        stage_ready_i = '0;
        stage_drop_i  = '0;
        cfg_bypass_i  = '0;
        out_empty_i   = 1'b1;
        clr_cnt_i     = 1'b0;
        check({tag, " completed in budget"}, int'(done), 1);
        check({tag, " started stages"}, int'(seen), int'(v.exp_starts));
        check({tag, " latency"}, latch_c, v.exp_lat);
        check({tag, " in_rd pulses"}, n_rd, 1);
        check({tag, " out_wr pulses"}, n_wr, int'(v.exp_fwd));
        if (clr_at_latch) begin
            m_pkt = 0;
            m_drop = 0;
            m_to = 0;
        end else begin
            if (v.exp_fwd) m_pkt = sat(m_pkt);
            else           m_drop = sat(m_drop);
            if (v.exp_to)  m_to = sat(m_to);
        end
        check({tag, " busy idle"}, int'(busy_o), 0);
        check({tag, " cur_stage idle"}, int'(cur_stage_o), 0);
        check_counters(tag);
        $display("pkt %s: latch at cycle %0d, rd %0d, wr %0d, cnt pkt=%0d drop=%0d to=%0d",
                 tag, latch_c, n_rd, n_wr, pkt_cnt_o, drop_cnt_o, timeout_cnt_o);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int s1;
        int s0;
        bit hit;
        //            bypass  tmo    d0  d1  d2  drop   free exp   lat fwd to
        vecs[0]  = '{3'b000, 16'd0, 3,  3,  3,  3'b000, 0, 3'b111, 14, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 16'd0, 3,  3,  3,  3'b000, 0, 3'b101, 10, 1'b1, 1'b0};
        vecs[2]  = '{3'b111, 16'd0, 3,  3,  3,  3'b000, 0, 3'b000, 2,  1'b1, 1'b0};
        vecs[3]  = '{3'b000, 16'd0, 3,  3,  3,  3'b010, 0, 3'b011, 10, 1'b0, 1'b0};
        vecs[4]  = '{3'b000, 16'd5, -1, 3,  3,  3'b000, 0, 3'b001, 8,  1'b0, 1'b1};
        vecs[5]  = '{3'b000, 16'd5, 5,  1,  1,  3'b000, 0, 3'b111, 12, 1'b1, 1'b0};
        vecs[6]  = '{3'b000, 16'd4, 4,  4,  4,  3'b000, 0, 3'b111, 17, 1'b1, 1'b0};
        vecs[7]  = '{3'b110, 16'd3, 2,  3,  3,  3'b000, 14, 3'b001, 15, 1'b1, 1'b0};
        vecs[8]  = '{3'b000, 16'd0, 1,  1,  2,  3'b100, 0, 3'b111, 9,  1'b0, 1'b0};
        vecs[9]  = '{3'b011, 16'd2, 3,  3,  -1, 3'b000, 0, 3'b100, 5,  1'b0, 1'b1};
        vecs[10] = '{3'b011, 16'd0, 3,  3,  0,  3'b000, 0, 3'b100, 4,  1'b1, 1'b0};

        // Reset state
        #1;
        check("reset busy", int'(busy_o), 0);
        check("reset start", int'(stage_start_o), 0);
        check("reset in_rd", int'(in_rd_o), 0);
        check("reset out_wr", int'(out_wr_o), 0);
        check("reset cur_stage", int'(cur_stage_o), 0);
        check_counters("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle busy", int'(busy_o), 0);

        for (int k = 0; k < NV; k++) begin
            run_pkt($sformatf("v%0d", k), vecs[k], 1'b0);
        end

        // Counter saturation at 15
        for (int k = 0; k < 12; k++) begin
            run_pkt($sformatf("sat%0d", k), vecs[2], 1'b0);
        end

        // Clear asserted in the same cycle as an increment
        run_pkt("clr_with_inc", vecs[2], 1'b1);

        // Make counters nonzero before the mid-packet reset
        run_pkt("pre_reset", vecs[0], 1'b0);

        // Reset during stage 1 WAIT
        s0 = 0;
        s1 = 0;
        hit = 1'b0;
        cfg_bypass_i  = 3'b000;
        cfg_timeout_i = '0;
        in_empty_i    = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #1;
            in_empty_i = 1'b1;
            if (stage_start_o[0]) s0 = c;
            if (stage_start_o[1]) s1 = c;
            stage_ready_i[0] = (s0 > 0) && ((c - s0) >= 2);
            if ((s1 > 0) && (c == s1 + 2)) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_mid reached stage1 wait", int'(hit), 1);
        check("rst_mid busy before", int'(busy_o), 1);
        check("rst_mid cur_stage before", int'(cur_stage_o), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid busy async", int'(busy_o), 0);
        check("rst_mid cur_stage async", int'(cur_stage_o), 0);
        check("rst_mid start async", int'(stage_start_o), 0);
        check("rst_mid pkt_cnt async", int'(pkt_cnt_o), 0);
        stage_ready_i = '0;
        m_pkt = 0;
        m_drop = 0;
        m_to = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_mid no in_rd", int'(in_rd_o), 0);
            check("rst_mid no out_wr", int'(out_wr_o), 0);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("post_rst no in_rd", int'(in_rd_o), 0);
            check("post_rst idle", int'(busy_o), 0);
        end
        check_counters("post_rst");
        $display("pkt rst_mid: reset applied during stage 1 wait");

        run_pkt("after_reset", vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
